// File: rtl/multibyte_add_seq_pkg.sv
// ---------------------------------------------------------------------------
// multibyte_add_seq_pkg
// Shared definitions for the sequential multi-precision adder/subtractor:
// FSM state encodings, byte width, and the operand-width default and legal
// range.
// ---------------------------------------------------------------------------
package multibyte_add_seq_pkg;

    localparam int BYTE           = 8;
    localparam int NBYTES_DEFAULT = 4;
    localparam int NBYTES_MIN     = 2;
    localparam int NBYTES_MAX     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multibyte_add_seq_if.sv
// ---------------------------------------------------------------------------
// multibyte_add_seq_if
// Request/result bundle for multibyte_add_seq.
//   master : drives start, sub, ci, a, b; observes busy, done, y, c, n, v, z
//   slave  : the adder block itself (mirror of master)
// ---------------------------------------------------------------------------
interface multibyte_add_seq_if
    import multibyte_add_seq_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) ();

    logic                   start;
    logic                   sub;
    logic                   ci;
    logic [BYTE*NBYTES-1:0] a;
    logic [BYTE*NBYTES-1:0] b;
    logic                   busy;
    logic                   done;
    logic [BYTE*NBYTES-1:0] y;
    logic                   c;
    logic                   n;
    logic                   v;
    logic                   z;

    modport master (
        output start, sub, ci, a, b,
        input  busy, done, y, c, n, v, z
    );

    modport slave (
        input  start, sub, ci, a, b,
        output busy, done, y, c, n, v, z
    );

endinterface

// File: rtl/multibyte_add_seq_adder.sv
// ---------------------------------------------------------------------------
// adder
// The shared 8-bit combinational adder with NZCV-style flags.
//   a, b : byte operands        ci : carry in
//   y    : sum byte             c  : carry out of bit 7
//   n    : y[7]                 v  : carry into bit 7 xor carry out
//   z    : y == 0
// ---------------------------------------------------------------------------
module adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] y,
    output logic       c,
    output logic       n,
    output logic       v,
    output logic       z
);

    logic [8:0] sum;
    logic       c_into_msb;

    assign sum        = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    // The sum bit is a^b^carry_in, so the carry into bit 7 falls back out.
    assign c_into_msb = a[7] ^ b[7] ^ sum[7];

    assign y = sum[7:0];
    assign c = sum[8];
    assign n = sum[7];
    assign v = c_into_msb ^ sum[8];
    assign z = ~|sum[7:0];

endmodule

// File: rtl/multibyte_add_seq.sv
// ---------------------------------------------------------------------------
// multibyte_add_seq
// Wide add/subtract computed one byte per clock through a single 8-bit
// adder, with the inter-byte carry held in a register.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of multibyte_add_seq_if
//           start/sub/ci/a/b in; busy/done/y/c/n/v/z out (all registered)
// Result is valid from the done pulse, NBYTES+1 edges after acceptance.
// ---------------------------------------------------------------------------
module multibyte_add_seq
    import multibyte_add_seq_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    multibyte_add_seq_if.slave    bus
);

    localparam int W     = BYTE * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);

    if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
        $error("multibyte_add_seq: NBYTES out of range");
    end

    state_t             state;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;     // already inverted when subtracting
    logic [W-1:0]       y_r;
    logic               carry_r;
    logic               zacc;    // AND of per-byte Z so far
    logic [IDX_W-1:0]   idx;
    logic               busy_r, done_r;
    logic               c_r, n_r, v_r, z_r;

    logic [BYTE-1:0]    add_a, add_b, add_y;
    logic               add_c, add_n, add_v, add_z;
    logic               last_byte;

    assign add_a     = a_r[idx*BYTE +: BYTE];
    assign add_b     = b_r[idx*BYTE +: BYTE];
    assign last_byte = (idx == IDX_W'(NBYTES - 1));

    adder u_adder (
        .a  (add_a),
        .b  (add_b),
        .ci (carry_r),
        .y  (add_y),
        .c  (add_c),
        .n  (add_n),
        .v  (add_v),
        .z  (add_z)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would let idx/carry_r updates
    // leak into the same edge's byte mux.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            y_r     <= '0;
            carry_r <= 1'b0;
            zacc    <= 1'b0;
            idx     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            c_r     <= 1'b0;
            n_r     <= 1'b0;
            v_r     <= 1'b0;
            z_r     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.ci;
                        idx     <= '0;
                        zacc    <= 1'b1;
                        busy_r  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state   <= IDLE;
                    end
                end

                RUN: begin
                    y_r[idx*BYTE +: BYTE] <= add_y;
                    carry_r <= add_c;
                    zacc    <= zacc & add_z;
                    if (last_byte) begin
                        c_r    <= add_c;
                        n_r    <= add_n;
                        v_r    <= add_v;
                        z_r    <= zacc & add_z;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx    <= idx + 1'b1;
                    end
                end

                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.y    = y_r;
    assign bus.c    = c_r;
    assign bus.n    = n_r;
    assign bus.v    = v_r;
    assign bus.z    = z_r;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// ---------------------------------------------------------------------------
// tb_multibyte_add_seq
// Directed bench for multibyte_add_seq at NBYTES=4. Inputs are driven and
// outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_multibyte_add_seq;

    localparam int NB = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multibyte_add_seq_if #(.NBYTES(NB)) bus ();

    multibyte_add_seq #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flags packed as {c, n, v, z}
    function automatic logic [3:0] flags();
        return {bus.c, bus.n, bus.v, bus.z};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic sv, input logic cv,
                          input logic [31:0] ey, input logic [3:0] ef);
        int lat;
        bit seen;
        @(negedge clk);
        bus.a = av; bus.b = bv; bus.sub = sv; bus.ci = cv; bus.start = 1'b1;
        @(negedge clk);
        // scramble operands after acceptance; they must not matter
        bus.start = 1'b0; bus.a = ~av; bus.b = 32'h5A5A_5A5A; bus.sub = ~sv; bus.ci = ~cv;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.done) seen = 1'b1;
        end
        check({tag, "_lat"}, 64'(lat), 64'(NB));
        check({tag, "_y"}, 64'(bus.y), 64'(ey));
        check({tag, "_flags"}, 64'(flags()), 64'(ef));
        check({tag, "_busy_lo"}, 64'(bus.busy), 64'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_hold"}, 64'({bus.y, flags()}), 64'({ey, ef}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones, first, last;
        bit gap_ok;
        checks = 0;
        errors = 0;
        rst_n = 1'b1;
        bus.start = 1'b0; bus.sub = 1'b0; bus.ci = 1'b0; bus.a = '0; bus.b = '0;

        // asynchronous reset asserted mid-cycle
        #13 rst_n = 1'b0;
        #1;
        check("rst_ctrl", 64'({bus.busy, bus.done}), 64'd0);
        check("rst_y", 64'(bus.y), 64'd0);
        check("rst_flags", 64'(flags()), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //      tag        a             b             sub   ci    y             {c,n,v,z}
        run_op("inc_byte", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 4'b0000);
        run_op("ripple",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 4'b1001);
        run_op("ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 4'b0110);
        run_op("sub_neg",  32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 4'b0100);
        run_op("sub_pos",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 4'b1000);
        run_op("z_top",    32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0001, 4'b0000);
        run_op("z_all",    32'h0000_0100, 32'hFFFF_FF00, 1'b0, 1'b0, 32'h0000_0000, 4'b1001);
        run_op("ci_add",   32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 32'h1234_5679, 4'b0000);

        // back-to-back: start held high, done every NB+1 cycles
        @(negedge clk);
        bus.a = 32'h0000_0001; bus.b = 32'h0000_0002; bus.sub = 1'b0; bus.ci = 1'b0;
        bus.start = 1'b1;
        dones = 0; first = 0; last = 0; gap_ok = 1'b1;
        for (int k = 1; k <= 3 * (NB + 1); k++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (dones == 1) first = k;
                else if (k - last != NB + 1) gap_ok = 1'b0;
                last = k;
                check("b2b_y", 64'(bus.y), 64'h3);
            end
        end
        bus.start = 1'b0;
        check("b2b_count", 64'(dones), 64'd3);
        check("b2b_first", 64'(first), 64'(NB + 1));
        check("b2b_gap", 64'(gap_ok), 64'd1);
        @(negedge clk);
        check("b2b_idle", 64'(bus.busy), 64'd0);

        // abort during the third RUN cycle
        @(negedge clk);
        bus.a = 32'h1111_1111; bus.b = 32'h2222_2222; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_pre", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctrl", 64'({bus.busy, bus.done}), 64'd0);
        check("abort_y", 64'(bus.y), 64'd0);
        check("abort_flags", 64'(flags()), 64'd0);
        #2 rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 2 * (NB + 1); k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        run_op("post_abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multibyte_add_seq.md
# multibyte_add_seq

Sequential multi-precision adder/subtractor. It processes a wide operand pair one byte per clock through a single instance of the team's 8-bit ripple `adder` module, carrying between bytes in a register. It sits directly upstream of `adder`, supplying its A/B/CI each cycle and consuming its Y, C, N, V and Z. It then presents the assembled wide result and flags to the datapath with a start/done handshake.

## Interface
- NBYTES, 4: number of 8-bit bytes per operand; legal 2..8.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when busy=0.
- sub  in  1  1 = subtract: B bytes are bit-inverted before the adder.
- ci  in  1  carry-in to byte 0, used as-is. Plain subtract requires ci=1.
- a  in  8*NBYTES  operand A, byte 0 = a[7:0].
- b  in  8*NBYTES  operand B.
- busy  out  1  high while the operation is in RUN.
- done  out  1  one-cycle pulse; y and flags are valid from this cycle.
- y  out  8*NBYTES  result.
- c  out  1  carry-out of the top byte.
- n  out  1  y[8*NBYTES-1].
- v  out  1  signed overflow of the top byte (carry into MSB xor carry out).
- z  out  1  1 iff the whole y is zero.

## Operation
- States are IDLE, RUN and DONE. Reset value is IDLE, with busy=0, done=0, y=0, c=n=v=z=0.
- IDLE/DONE with start=1: go to RUN.
  - Latch a → A_r.
  - Latch (sub ? ~b : b) → B_r.
  - carry_r ← ci, idx ← 0, zacc ← 1.
- start is ignored while busy=1. Operand changes after acceptance have no effect.
- RUN, each cycle:
  - Adder inputs are A_r byte idx, B_r byte idx, and CI=carry_r.
  - On the edge: y byte idx ← Y, carry_r ← C, zacc ← zacc & Z, idx ← idx+1.
- RUN with idx = NBYTES-1:
  - Additionally c ← C, n ← N, v ← V, z ← zacc & Z.
  - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is accepted, giving back-to-back operation.
- y and the flags hold their last values until the next accepted start.
  - y bytes are overwritten progressively during RUN, so y is only meaningful when done=1 or afterwards.
  - c, n, v and z change only on the final RUN edge.
- Arithmetic is modulo 2^(8*NBYTES). idx width is clog2(NBYTES); no wrap is reachable because the transition leaves RUN at NBYTES-1.
- Reset mid-operation aborts immediately: all outputs return to their reset values and no done is produced.

## Timing
- start accepted at edge T0.
- RUN occupies cycles T0..T0+NBYTES-1 (edges T1..T_NBYTES).
- done=1 in the cycle after edge T_NBYTES, so latency is NBYTES+1 edges from acceptance.
- Throughput is one operation per NBYTES+1 cycles.
- busy rises the cycle after acceptance and falls when done rises.
- The critical path is one 8-bit ripple (`adder`) plus register setup. There are no combinational paths from inputs to outputs.

## Structure
- Shared package/header holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - the NBYTES default and legal range
  - a BYTE width constant of 8
- Exactly one sub-module: an instance of the existing 8-bit `adder`. All sequencing and byte muxing stays in this block.

## Test plan
- Reset values (NBYTES=4):
  - Assert rst_n=0 asynchronously mid-cycle → all outputs go to 0 immediately.
  - Release, start with a=0x000000FF, b=0x00000001, ci=0, sub=0 → done at T0+5, y=0x00000100, c=0, n=0, v=0, z=0.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, ci=0 → y=0x00000000, c=1, z=1, n=0, v=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 → y=0x80000000, n=1, v=1, c=0, z=0.
- Subtract: a=0x00000005, b=0x00000007, sub=1, ci=1 → y=0xFFFFFFFE, c=0, n=1, v=0, z=0.
  - Then a=7, b=5 → y=0x00000002, c=1.
- Zero accumulation: a=0x00000001, b=0 → z=0 (top-byte Z=1 must not set z).
  - a=0x00000100, b=0xFFFFFF00 → y=0, c=1, z=1.
- Handshake and abort:
  - start asserted on every cycle while busy=1 → ignored; exactly one done per NBYTES+1 cycles in back-to-back mode.
  - rst_n pulsed low during the third RUN cycle → no done, busy=0, outputs 0.
  - Next operation then completes correctly.
